// File: rtl/seg_message_scroller_pkg.sv
// seg_message_scroller_pkg: shared constants, state encoding and width helpers.
// Rev 1.0
`default_nettype none

package seg_message_scroller_pkg;

    localparam logic [7:0] ASCII_BLANK = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATIC = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    function automatic int addr_width(input int max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

    // One extra bit so a length of exactly MAX_LEN and the trailing blank slot are representable.
    function automatic int idx_width(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_message_scroller_if.sv
// seg_message_scroller_if: board-control side buffer/command signals and display outputs.
// Rev 1.0
`default_nettype none

interface seg_message_scroller_if #(
    parameter int DIGITS  = 5,
    parameter int MAX_LEN = 16
);
    import seg_message_scroller_pkg::*;

    localparam int AW = addr_width(MAX_LEN);
    localparam int IW = idx_width(MAX_LEN);

    logic                WrEn;
    logic [AW-1:0]       WrAddr;
    logic [7:0]          WrChar;
    logic [IW-1:0]       Len;
    logic                Start;
    logic                Stop;
    logic [8*DIGITS-1:0] DigitChar;
    logic                Busy;
    logic                Wrap;

    modport master (
        output WrEn, WrAddr, WrChar, Len, Start, Stop,
        input  DigitChar, Busy, Wrap
    );

    modport slave (
        input  WrEn, WrAddr, WrChar, Len, Start, Stop,
        output DigitChar, Busy, Wrap
    );

endinterface

`default_nettype wire

// File: rtl/seg_message_scroller_tick.sv
// seg_tick_divider: counts 0..TICK_DIV-1 while enabled, one-cycle tick on the last count.
// Rev 1.0
`default_nettype none

module seg_tick_divider #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/seg_message_scroller.sv
// seg_message_scroller: message buffer plus static/scrolling window feeding per-digit ASCII decoders.
// Rev 1.0
`default_nettype none

module seg_message_scroller #(
    parameter int DIGITS   = 5,
    parameter int MAX_LEN  = 16,
    parameter int TICK_DIV = 12500000
) (
    input  logic Clk,
    input  logic Rst_n,
    seg_message_scroller_if.slave bus
);
    import seg_message_scroller_pkg::*;

    localparam int AW = addr_width(MAX_LEN);
    localparam int IW = idx_width(MAX_LEN);
    localparam logic [IW-1:0] MAX_LEN_W = IW'(MAX_LEN);
    localparam logic [IW-1:0] DIGITS_W  = IW'(DIGITS);

    state_t              state, state_next;
    logic [IW-1:0]       pos, pos_next;
    logic [IW-1:0]       len_q, len_next, len_clamped;
    logic                wrap_pend, wrap_next;
    logic                tick, tick_clear;
    logic [7:0]          msg_buf [MAX_LEN];
    logic [8*DIGITS-1:0] window;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < MAX_LEN; k++) msg_buf[k] <= ASCII_BLANK;
        end else if (bus.WrEn) begin
            msg_buf[bus.WrAddr] <= bus.WrChar;
        end
    end

    assign len_clamped = (bus.Len > MAX_LEN_W) ? MAX_LEN_W : bus.Len;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            pos       <= '0;
            len_q     <= '0;
            wrap_pend <= 1'b0;
        end else begin
            state     <= state_next;
            pos       <= pos_next;
            len_q     <= len_next;
            wrap_pend <= wrap_next;
        end
    end

    always_comb begin
        state_next = state;
        pos_next   = pos;
        len_next   = len_q;
        wrap_next  = 1'b0;
        tick_clear = 1'b0;
        if (bus.Stop) begin
            state_next = ST_IDLE;
            pos_next   = '0;
            tick_clear = 1'b1;
        end else if (bus.Start) begin
            len_next   = len_clamped;
            pos_next   = '0;
            tick_clear = 1'b1;
            if (len_clamped == '0)
                state_next = ST_IDLE;
            else if (len_clamped <= DIGITS_W)
                state_next = ST_STATIC;
            else
                state_next = ST_SCROLL;
        end else if (state == ST_SCROLL && tick) begin
            if (pos == len_q) begin
                pos_next  = '0;
                wrap_next = 1'b1;
            end else begin
                pos_next = pos + 1'b1;
            end
        end
    end

    seg_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .enable (state == ST_SCROLL),
        .clear  (tick_clear),
        .tick   (tick)
    );

    // In SCROLL, pos+i stays below 2*(L+1), so a single conditional subtract wraps it.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [IW-1:0] raw_idx, idx;
        assign raw_idx = pos + IW'(g);
        assign idx     = (raw_idx > len_q) ? raw_idx - (len_q + 1'b1) : raw_idx;
        assign window[8*(DIGITS-1-g) +: 8] =
            (state == ST_IDLE)   ? ASCII_BLANK :
            (state == ST_STATIC) ? ((IW'(g) < len_q) ? msg_buf[g] : ASCII_BLANK) :
            (idx == len_q)       ? ASCII_BLANK : msg_buf[idx[AW-1:0]];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bus.DigitChar <= {DIGITS{ASCII_BLANK}};
            bus.Busy      <= 1'b0;
            bus.Wrap      <= 1'b0;
        end else begin
            bus.DigitChar <= window;
            bus.Busy      <= (state != ST_IDLE);
            bus.Wrap      <= wrap_pend;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_message_scroller.sv
// tb_seg_message_scroller: table-driven vectors plus directed scroll/clamp/reset sequences.
// Rev 1.0
`default_nettype none

module tb_seg_message_scroller;
    import seg_message_scroller_pkg::*;

    localparam int DIGITS   = 5;
    localparam int MAX_LEN  = 16;
    localparam int TICK_DIV = 4;
    localparam logic [39:0] BLANK5 = "     ";
    localparam logic [39:0] HI     = "Hi   ";

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    seg_message_scroller_if #(.DIGITS(DIGITS), .MAX_LEN(MAX_LEN)) bus ();

    seg_message_scroller #(
        .DIGITS   (DIGITS),
        .MAX_LEN  (MAX_LEN),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        wr_en;
        logic [3:0]  addr;
        logic [7:0]  ch;
        logic [4:0]  len;
        logic        start;
        logic        stop;
        logic [39:0] exp_chars;
        logic        exp_busy;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs [20];
    int n_checks = 0;
    int n_pass   = 0;
    logic [39:0] hello_win [7];
    logic [47:0] hello_msg;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got '%s' (%h) expected '%s' (%h)", name, act, act, exp, exp);
    endtask

    task automatic check_out(input string name, input logic [39:0] chars, input logic busy, input logic wrap);
        check({name, " chars"}, bus.DigitChar, chars);
        check({name, " busy"}, 40'(bus.Busy), 40'(busy));
        check({name, " wrap"}, 40'(bus.Wrap), 40'(wrap));
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        bus.WrEn  = 1'b0;
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
    endtask

    task automatic write_char(input logic [3:0] addr, input logic [7:0] ch);
        bus.WrEn   = 1'b1;
        bus.WrAddr = addr;
        bus.WrChar = ch;
        step();
    endtask

    task automatic start_len(input logic [4:0] len);
        bus.Len   = len;
        bus.Start = 1'b1;
        step();
    endtask

    task automatic write_hello();
        for (int k = 0; k < 6; k++) write_char(4'(k), hello_msg[47-8*k -: 8]);
    endtask

    int n_wraps, first_wrap, second_wrap;

    initial begin
        bus.WrEn = 1'b0; bus.WrAddr = '0; bus.WrChar = '0;
        bus.Len = '0; bus.Start = 1'b0; bus.Stop = 1'b0;
        hello_msg = "Hello!";
        hello_win = '{"Hello", "ello!", "llo! ", "lo! H", "o! He", "! Hel", " Hell"};

        //                wr  addr  ch   len  st  sp  expected   busy wrap
        vecs[0]  = '{1'b1, 4'd0, "H", 5'd0, 1'b0, 1'b0, BLANK5,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd1, "i", 5'd0, 1'b0, 1'b0, BLANK5,  1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'd0, "-", 5'd2, 1'b1, 1'b0, BLANK5,  1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, "-", 5'd0, 1'b0, 1'b0, HI,      1'b1, 1'b0};
        vecs[4]  = '{1'b1, 4'd3, "X", 5'd0, 1'b0, 1'b0, HI,      1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, "-", 5'd0, 1'b0, 1'b0, HI,      1'b1, 1'b0};
        vecs[6]  = '{1'b1, 4'd0, "Y", 5'd0, 1'b0, 1'b0, HI,      1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'd0, "-", 5'd0, 1'b0, 1'b0, "Yi   ", 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 4'd0, "H", 5'd0, 1'b0, 1'b0, "Yi   ", 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, "-", 5'd0, 1'b1, 1'b0, HI,      1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'd0, "-", 5'd0, 1'b0, 1'b0, BLANK5,  1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'd0, "-", 5'd2, 1'b1, 1'b1, BLANK5,  1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'd0, "-", 5'd0, 1'b0, 1'b0, BLANK5,  1'b0, 1'b0};
        vecs[13] = '{1'b0, 4'd0, "-", 5'd2, 1'b1, 1'b0, BLANK5,  1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'd0, "-", 5'd0, 1'b0, 1'b1, HI,      1'b1, 1'b0};
        vecs[15] = '{1'b0, 4'd0, "-", 5'd0, 1'b0, 1'b0, BLANK5,  1'b0, 1'b0};
        vecs[16] = '{1'b0, 4'd0, "-", 5'd5, 1'b1, 1'b0, BLANK5,  1'b0, 1'b0};
        vecs[17] = '{1'b0, 4'd0, "-", 5'd0, 1'b0, 1'b0, "Hi X ", 1'b1, 1'b0};
        vecs[18] = '{1'b0, 4'd0, "-", 5'd0, 1'b0, 1'b1, "Hi X ", 1'b1, 1'b0};
        vecs[19] = '{1'b0, 4'd0, "-", 5'd0, 1'b0, 1'b0, BLANK5,  1'b0, 1'b0};

        repeat (3) @(posedge Clk);
        #1;
        check_out("in reset", BLANK5, 1'b0, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            step();
            check_out($sformatf("idle c%0d", c), BLANK5, 1'b0, 1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            bus.WrEn   = vecs[i].wr_en;
            bus.WrAddr = vecs[i].addr;
            bus.WrChar = vecs[i].ch;
            bus.Len    = vecs[i].len;
            bus.Start  = vecs[i].start;
            bus.Stop   = vecs[i].stop;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_chars, vecs[i].exp_busy, vecs[i].exp_wrap);
        end

        // Static message must hold with no wrap activity.
        start_len(5'd2);
        for (int c = 1; c <= 40; c++) begin
            step();
            check_out($sformatf("static c%0d", c), HI, 1'b1, 1'b0);
        end

        // Hello! scrolls: one window per TICK_DIV cycles, wrap on the 7th step.
        write_hello();
        start_len(5'd6);
        for (int c = 1; c <= 32; c++) begin
            step();
            check_out($sformatf("scroll c%0d", c), hello_win[((c - 1) / 4) % 7], 1'b1, c == 29);
        end

        write_char(4'd1, "E");
        check_out("wr E same", "ello!", 1'b1, 1'b0);
        step();
        check_out("wr E next", "Ello!", 1'b1, 1'b0);
        bus.Len = 5'd6; bus.Start = 1'b1; bus.Stop = 1'b1;
        step();
        check_out("start+stop edge", "Ello!", 1'b1, 1'b0);
        step();
        check_out("start+stop after", BLANK5, 1'b0, 1'b0);

        start_len(5'd0);
        step();
        check_out("len0 c1", BLANK5, 1'b0, 1'b0);
        step();
        check_out("len0 c2", BLANK5, 1'b0, 1'b0);

        // Len=20 clamps to 16: 17 positions, wrap every 68 cycles.
        n_wraps = 0; first_wrap = 0; second_wrap = 0;
        start_len(5'd20);
        for (int c = 1; c <= 140; c++) begin
            step();
            if (bus.Wrap) begin
                n_wraps++;
                if (n_wraps == 1) first_wrap = c;
                else if (n_wraps == 2) second_wrap = c;
            end
            if (c == 1)  check("clamp pos0",  bus.DigitChar, "HEllo");
            if (c == 61) check("clamp pos15", bus.DigitChar, "  HEl");
            if (c == 65) check("clamp pos16", bus.DigitChar, " HEll");
            if (c == 69) check("clamp wrap window", bus.DigitChar, "HEllo");
        end
        check("clamp wrap count", 40'(n_wraps), 40'd2);
        check("clamp first wrap", 40'(first_wrap), 40'd69);
        check("clamp second wrap", 40'(second_wrap), 40'd137);

        // Asynchronous reset mid-scroll, away from any clock edge.
        start_len(5'd6);
        repeat (10) step();
        #3;
        Rst_n = 1'b0;
        #1;
        check_out("async reset", BLANK5, 1'b0, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        start_len(5'd6);
        step();
        check_out("buffer cleared", BLANK5, 1'b1, 1'b0);

        write_hello();
        start_len(5'd6);
        step();
        check_out("resume pos0", "Hello", 1'b1, 1'b0);
        repeat (4) step();
        check_out("resume pos1", "ello!", 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_message_scroller.md
# seg_message_scroller

Sequencer that drives a row of seven-segment digits from a message buffer. It holds up to MAX_LEN ASCII characters and presents DIGITS registered ASCII codes per cycle, one per digit decoder. Messages that fit are shown statically; longer ones scroll right-to-left on a divided tick. It sits between board control logic (keys/switches) and the per-digit ASCII-to-segment decoders.

## Interface
- DIGITS, 5, number of display digits driven
- MAX_LEN, 16, message buffer depth (power of two)
- TICK_DIV, 12500000, clock cycles per scroll step (≥2)
- Clk  input  1  system clock, all logic on rising edge
- Rst_n  input  1  asynchronous, active-low reset
- WrEn  input  1  write WrChar into buffer at WrAddr this cycle
- WrAddr  input  $clog2(MAX_LEN)  buffer write address
- WrChar  input  8  ASCII character to write
- Len  input  $clog2(MAX_LEN)+1  message length, sampled only on Start (values >MAX_LEN clamp to MAX_LEN)
- Start  input  1  one-cycle pulse: latch Len, restart display at position 0
- Stop  input  1  one-cycle pulse: return to IDLE, blank digits
- DigitChar  output  8*DIGITS  ASCII per digit; bits [8*DIGITS-1 -: 8] = leftmost digit
- Busy  output  1  high in STATIC or SCROLL
- Wrap  output  1  one-cycle pulse when scroll position returns to 0

## Operation
- Blank character is 8'h20 (space); decoders render it with all segments off.
- Buffer: MAX_LEN×8 registers; writes accepted in every state; reset fills with 8'h20.
- States: IDLE, STATIC, SCROLL.
- IDLE: all digits blank. Start with latched length L=0 → stay IDLE; 1≤L≤DIGITS → STATIC; L>DIGITS → SCROLL.
- STATIC: digit i (0 = leftmost) shows buf[i] for i<L, else blank. No tick activity, Wrap never asserts.
- SCROLL: virtual circular stream of L+1 chars = buf[0..L-1] followed by one blank. Position pos ∈ [0, L]. Digit i shows stream[(pos+i) mod (L+1)]. Each tick pos increments; at pos=L next tick sets pos=0 and pulses Wrap.
- Start in any state: re-latch Len, pos=0, tick counter=0, re-enter state per rules above.
- Stop in any state → IDLE, pos=0, counter=0. Start and Stop in same cycle: Stop wins.
- Buffer write to a displayed address appears on DigitChar one cycle after write (next output register update).
- Modulo arithmetic: index width $clog2(MAX_LEN)+1; wrap by compare-and-subtract, no divider.

## Timing
- Reset (async assert, sync release): state IDLE, pos 0, counter 0, latched L 0, DigitChar all 8'h20, Busy 0, Wrap 0.
- DigitChar, Busy, Wrap are registered; reflect state/pos/buffer one cycle after the causing edge.
- Start at edge N: Busy=1 and first window visible after edge N+1.
- Tick counter counts 0..TICK_DIV-1 in SCROLL only; pos advances at the edge where counter = TICK_DIV-1; first step TICK_DIV cycles after Start.
- Wrap high exactly one cycle, coincident with the window showing pos=0.
- Reset mid-scroll: immediate blanking, buffer contents lost.

## Structure
- Shared package: ASCII_BLANK = 8'h20, state enum (IDLE/STATIC/SCROLL), width helpers.
- One sub-module natural: seg_tick_divider (parameter TICK_DIV, enable, clear, one-cycle tick out).
- Window mux (DIGITS parallel index computations) stays in the top module.

## Test plan (TICK_DIV=4, DIGITS=5, MAX_LEN=16)
- Reset then idle 10 cycles -> DigitChar all 8'h20, Busy 0, Wrap 0 throughout.
- Write "Hi", Start Len=2 -> next cycle DigitChar "Hi   ", Busy 1, no change after 40 cycles, Wrap never.
- Write "Hello!" (L=6), Start -> "Hello", after 4 cycles "ello!", then "llo! ", "lo! H", ..., 7th step back to "Hello" with Wrap pulse of one cycle.
- During SCROLL write buf[1]='E' -> next cycle digit showing index 1 shows 'E'; Start and Stop same cycle -> IDLE, all blank, Busy 0.
- Start with Len=0 -> remains IDLE, Busy 0; Len=20 -> clamped to 16, scroll period 17 steps between Wrap pulses.
- Assert Rst_n low mid-scroll (non-edge-aligned) -> outputs blank immediately; after release and rewrite+Start, scrolling resumes from pos 0.
